// File: rtl/mem_if_pkg.sv
// Shared definitions for the MFA/MFC memory handshake: state encoding,
// request attribute encodings and the latency counter width.
package mem_if_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic WB_WORD  = 1'b1;
   localparam logic WB_BYTE  = 1'b0;

   localparam int CNT_W = 4;

endpackage

// File: rtl/byte_ram.sv
// Four independent byte lanes sharing one word address: synchronous write
// with per-lane enables, combinational read. Lane i lives in bits [8i+7:8i].
module byte_ram #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  Clk,
   input  logic [ADDR_WIDTH-3:0] word_addr,
   input  logic [3:0]            wr_en,
   input  logic [31:0]           wr_data,
   output logic [31:0]           rd_data
);

   localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

   for (genvar lane = 0; lane < 4; lane++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge Clk) begin
         if (wr_en[lane]) lane_mem[word_addr] <= wr_data[8*lane +: 8];
      end

      assign rd_data[8*lane +: 8] = lane_mem[word_addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory side of the MFA/MFC handshake: latches a request, waits LATENCY
// edges, performs the big-endian word/byte access, then holds MFC until MFA drops.
module mem_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MFA,
   input  logic        READ_WRITE,
   input  logic        WORD_BYTE,
   input  logic [31:0] Address,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        MFC
);

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      count;
   logic                  rw_q, wb_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           data_q;
   logic                  accept, complete;
   logic [3:0]            wr_en;
   logic [31:0]           wr_data, rd_data, rd_value;
   logic [1:0]            offset;

   assign offset = addr_q[1:0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (MFA) state_nxt = BUSY;
         BUSY:    if (!MFA) state_nxt = IDLE;
                  else if (count == '0) state_nxt = DONE;
         DONE:    if (!MFA) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Offset 0 is the most significant byte, which sits in lane 3.
   always_comb begin
      MFC      = (state == DONE);
      accept   = (state == IDLE) && MFA;
      complete = (state == BUSY) && MFA && (count == '0);
      wr_en    = 4'b0000;
      wr_data  = data_q;
      if (complete && rw_q == RW_WRITE) begin
         if (wb_q == WB_WORD) begin
            wr_en = 4'b1111;
         end else begin
            wr_en   = 4'b1000 >> offset;
            wr_data = {4{data_q[7:0]}};
         end
      end
   end

   always_comb begin
      rd_value = rd_data;
      if (wb_q == WB_BYTE) begin
         case (offset)
            2'd0:    rd_value = {24'h0, rd_data[31:24]};
            2'd1:    rd_value = {24'h0, rd_data[23:16]};
            2'd2:    rd_value = {24'h0, rd_data[15:8]};
            default: rd_value = {24'h0, rd_data[7:0]};
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count   <= '0;
         DataOut <= '0;
      end else begin
         if (accept)
            count <= CNT_W'(LATENCY - 1);
         else if (state == BUSY && MFA && count != '0)
            count <= count - 1'b1;
         if (complete && rw_q == RW_READ)
            DataOut <= rd_value;
      end
   end

   // Request attributes are captured once at acceptance and ignored afterwards.
   always_ff @(posedge Clk) begin
      if (accept) begin
         rw_q   <= READ_WRITE;
         wb_q   <= WORD_BYTE;
         addr_q <= Address[ADDR_WIDTH-1:0];
         data_q <= DataIn;
      end
   end

   byte_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .Clk       (Clk),
      .word_addr (addr_q[ADDR_WIDTH-1:2]),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .rd_data   (rd_data)
   );

endmodule
